// File: rtl/exe_mem_skid_reg.sv
// exe_mem_skid_reg: elastic EXE->MEM pipeline register with a one-entry skid buffer.
// The main entry M drives the outputs. The skid entry S catches one extra entry,
// so in_ready depends only on registered state, freeze and rst.
// Ports:
//   clk, rst                        clock and asynchronous active-high reset
//   freeze, flush                   global stall / synchronous kill of held entries
//   in_valid, in_ready              upstream handshake
//   ctrl_in, dest_in, data_in       incoming payload (word 0 in data_in LSBs)
//   out_valid, out_ready            downstream handshake
//   ctrl_out, dest_out, data_out    outgoing payload (ctrl_out gated by out_valid)
//   occupancy                       entries held (0..2)
//   flush_cnt                       saturating count of valid entries killed by flush
module exe_mem_skid_reg #(
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned NUM_WORDS = 4,
   parameter int unsigned CTRL_W    = 3,
   parameter int unsigned DEST_W    = 4,
   parameter int unsigned CNT_W     = 8
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        freeze,
   input  logic                        flush,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [CTRL_W-1:0]           ctrl_in,
   input  logic [DEST_W-1:0]           dest_in,
   input  logic [DATA_W*NUM_WORDS-1:0] data_in,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [CTRL_W-1:0]           ctrl_out,
   output logic [DEST_W-1:0]           dest_out,
   output logic [DATA_W*NUM_WORDS-1:0] data_out,
   output logic [1:0]                  occupancy,
   output logic [CNT_W-1:0]            flush_cnt
);

   localparam int unsigned PAY_W = DATA_W * NUM_WORDS;
   localparam logic [CNT_W:0] CNT_MAX = {1'b0, {CNT_W{1'b1}}};

   logic              mv, sv;
   logic [CTRL_W-1:0] m_ctrl, s_ctrl;
   logic [DEST_W-1:0] m_dest, s_dest;
   logic [PAY_W-1:0]  m_data, s_data;
   logic [CNT_W-1:0]  cnt_q;

   logic              acc, deq;
   logic [1:0]        kill_num;
   logic [CNT_W:0]    cnt_sum;
   logic [CNT_W-1:0]  cnt_nxt;

   // Handshake and status outputs, derived only from registered state and stall/reset.
   always_comb begin
      in_ready  = ~sv & ~freeze & ~rst;
      out_valid = mv;
      ctrl_out  = mv ? m_ctrl : '0;
      dest_out  = m_dest;
      data_out  = m_data;
      occupancy = 2'({1'b0, mv}) + 2'({1'b0, sv});
      flush_cnt = cnt_q;
      acc       = in_valid & in_ready;
      deq       = mv & out_ready & ~freeze;
   end

   // Saturating add of entries discarded by a flush; an entry leaving on deq is not lost.
   always_comb begin
      kill_num = 2'({1'b0, mv & ~deq}) + 2'({1'b0, sv});
      cnt_sum  = (CNT_W+1)'(cnt_q) + (CNT_W+1)'(kill_num);
      cnt_nxt  = (cnt_sum > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : cnt_sum[CNT_W-1:0];
   end

   // Entry storage: flush beats freeze beats normal flow.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mv     <= 1'b0;
         sv     <= 1'b0;
         m_ctrl <= '0;
         m_dest <= '0;
         m_data <= '0;
         s_ctrl <= '0;
         s_dest <= '0;
         s_data <= '0;
         cnt_q  <= '0;
      end else if (flush) begin
         mv    <= 1'b0;
         sv    <= 1'b0;
         cnt_q <= cnt_nxt;
      end else if (!freeze) begin
         if (!mv) begin
            if (acc) begin
               mv     <= 1'b1;
               m_ctrl <= ctrl_in;
               m_dest <= dest_in;
               m_data <= data_in;
            end
         end else if (!sv) begin
            if (acc) begin
               if (deq) begin
                  m_ctrl <= ctrl_in;
                  m_dest <= dest_in;
                  m_data <= data_in;
               end else begin
                  sv     <= 1'b1;
                  s_ctrl <= ctrl_in;
                  s_dest <= dest_in;
                  s_data <= data_in;
               end
            end else if (deq) begin
               mv <= 1'b0;
            end
         end else if (deq) begin
            // Skid entry moves up; input is blocked while S is full.
            sv     <= 1'b0;
            m_ctrl <= s_ctrl;
            m_dest <= s_dest;
            m_data <= s_data;
         end
      end
   end

endmodule

// File: tb/tb_exe_mem_skid_reg.sv
module tb_exe_mem_skid_reg;

   logic         clk = 1'b0;
   logic         rst;
   logic         freeze, flush, in_valid, out_ready;
   logic [2:0]   ctrl_in;
   logic [3:0]   dest_in;
   logic [127:0] data_in;
   logic         in_ready, out_valid;
   logic [2:0]   ctrl_out;
   logic [3:0]   dest_out;
   logic [127:0] data_out;
   logic [1:0]   occupancy;
   logic [7:0]   flush_cnt;

   logic         flush2, in_valid2;
   logic         in_ready2, out_valid2;
   logic [2:0]   ctrl_out2;
   logic [3:0]   dest_out2;
   logic [127:0] data_out2;
   logic [1:0]   occupancy2;
   logic [1:0]   flush_cnt2;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   exe_mem_skid_reg dut (
      .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .ctrl_in(ctrl_in), .dest_in(dest_in), .data_in(data_in),
      .out_valid(out_valid), .out_ready(out_ready),
      .ctrl_out(ctrl_out), .dest_out(dest_out), .data_out(data_out),
      .occupancy(occupancy), .flush_cnt(flush_cnt)
   );

   exe_mem_skid_reg #(.CNT_W(2)) dut2 (
      .clk(clk), .rst(rst), .freeze(1'b0), .flush(flush2),
      .in_valid(in_valid2), .in_ready(in_ready2),
      .ctrl_in(ctrl_in), .dest_in(dest_in), .data_in(data_in),
      .out_valid(out_valid2), .out_ready(1'b0),
      .ctrl_out(ctrl_out2), .dest_out(dest_out2), .data_out(data_out2),
      .occupancy(occupancy2), .flush_cnt(flush_cnt2)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [127:0] d, input logic [3:0] t);
      in_valid = v;
      data_in  = d;
      dest_in  = t;
   endtask

   localparam logic [1:0] SAT_EXP [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

   initial begin
      rst = 1'b1; freeze = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      ctrl_in = 3'b000; dest_in = 4'h0; data_in = '0;
      flush2 = 1'b0; in_valid2 = 1'b0;
      #2;
      check("rst_out_valid", out_valid, 0);
      check("rst_occ", occupancy, 0);
      check("rst_in_ready", in_ready, 0);
      check("rst_data", data_out, 0);
      check("rst_flush_cnt", flush_cnt, 0);
      step(); step();
      rst = 1'b0;
      #1;
      check("rel_in_ready", in_ready, 1);

      // Streaming at full rate
      out_ready = 1'b1; ctrl_in = 3'b100;
      drive(1, 128'h11, 4'h1); step();
      check("strm_A", data_out, 128'h11);
      check("strm_A_dest", dest_out, 4'h1);
      check("strm_A_occ", occupancy, 1);
      drive(1, 128'h22, 4'h2); step();
      check("strm_B", data_out, 128'h22);
      check("strm_B_rdy", in_ready, 1);
      drive(1, 128'h33, 4'h3); step();
      check("strm_C", data_out, 128'h33);
      check("strm_C_occ", occupancy, 1);
      drive(0, 128'h44, 4'h4); step();
      check("strm_drain_valid", out_valid, 0);
      check("strm_drain_hold", data_out, 128'h33);
      check("strm_drain_ctrl", ctrl_out, 0);

      // Backpressure fills the skid entry
      out_ready = 1'b0;
      drive(1, 128'h11, 4'h1); step();
      drive(1, 128'h22, 4'h2); step();
      drive(0, 128'h0, 4'h0);
      check("bp_occ2", occupancy, 2);
      check("bp_in_ready", in_ready, 0);
      check("bp_head", data_out, 128'h11);
      out_ready = 1'b1; step();
      check("bp_deq1", data_out, 128'h22);
      check("bp_deq1_occ", occupancy, 1);
      check("bp_deq1_rdy", in_ready, 1);
      step();
      check("bp_deq2_occ", occupancy, 0);

      // Flush with both entries held and no dequeue: count 2, input discarded
      out_ready = 1'b0; ctrl_in = 3'b101;
      drive(1, 128'h11, 4'h1); step();
      drive(1, 128'h22, 4'h2); step();
      check("fl_ctrl", ctrl_out, 3'b101);
      drive(1, 128'h55, 4'h5); flush = 1'b1; step();
      flush = 1'b0; drive(0, 128'h0, 4'h0);
      check("fl_valid", out_valid, 0);
      check("fl_ctrl0", ctrl_out, 0);
      check("fl_occ", occupancy, 0);
      check("fl_cnt2", flush_cnt, 2);
      // Flush while the head is dequeued: only the skid entry counts
      drive(1, 128'h11, 4'h1); step();
      drive(1, 128'h22, 4'h2); step();
      drive(0, 128'h0, 4'h0); out_ready = 1'b1; flush = 1'b1; step();
      flush = 1'b0;
      check("fl_deq_cnt", flush_cnt, 3);
      check("fl_deq_occ", occupancy, 0);

      // Freeze holds everything, including an otherwise possible dequeue
      out_ready = 1'b0; ctrl_in = 3'b010;
      drive(1, 128'h66, 4'h6); step();
      drive(1, 128'h77, 4'h7); out_ready = 1'b1; freeze = 1'b1;
      #1;
      check("frz_in_ready", in_ready, 0);
      for (int i = 0; i < 3; i++) begin
         step();
         check("frz_occ", occupancy, 1);
         check("frz_data", data_out, 128'h66);
         check("frz_valid", out_valid, 1);
      end
      freeze = 1'b0; drive(0, 128'h0, 4'h0); step();
      check("frz_rel_occ", occupancy, 0);
      check("frz_rel_rdy", in_ready, 1);

      // Narrow counter saturates at 3
      for (int i = 0; i < 5; i++) begin
         in_valid2 = 1'b1; step();
         in_valid2 = 1'b0; flush2 = 1'b1; step();
         flush2 = 1'b0;
         check("sat_cnt", flush_cnt2, SAT_EXP[i]);
      end

      // Asynchronous reset mid-stream with two entries held
      out_ready = 1'b0; ctrl_in = 3'b111;
      drive(1, 128'h11, 4'h1); step();
      drive(1, 128'h22, 4'h2); step();
      drive(0, 128'h0, 4'h0);
      check("ar_pre_occ", occupancy, 2);
      #2 rst = 1'b1;
      #1;
      check("ar_valid", out_valid, 0);
      check("ar_ctrl", ctrl_out, 0);
      check("ar_dest", dest_out, 0);
      check("ar_data", data_out, 0);
      check("ar_occ", occupancy, 0);
      check("ar_cnt", flush_cnt, 0);
      #1 rst = 1'b0;
      step();
      check("ar_rel_rdy", in_ready, 1);
      check("ar_rel_cnt", flush_cnt, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/exe_mem_skid_reg.md
Name: exe_mem_skid_reg

Overview:
- Parametrised, elastic successor of the EXE->MEM pipeline register.
- Carries control bits, destination tag and N data words between the execute and memory stages.
- Uses a valid/ready handshake and a one-entry skid buffer, so backpressure never needs a combinational ready path.
- Adds synchronous flush (branch/exception kill), global freeze, occupancy output and a saturating flushed-entry counter.

Parameters:
- DATA_W, 32, width of each data word.
- NUM_WORDS, 4, data words per entry (default order: ALU result, Val_Rm, PC, instruction).
- CTRL_W, 3, control bits (default {WB_en, MEM_R_EN, MEM_W_EN}).
- DEST_W, 4, destination register tag width.
- CNT_W, 8, flush counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- freeze  in  1  global stall; holds all state.
- flush  in  1  synchronous kill of all held entries.
- in_valid  in  1  upstream entry valid.
- in_ready  out  1  stage can accept an entry.
- ctrl_in  in  CTRL_W  control bits.
- dest_in  in  DEST_W  destination tag.
- data_in  in  DATA_W*NUM_WORDS  packed data words, word 0 in LSBs.
- out_valid  out  1  output entry valid.
- out_ready  in  1  downstream accepts.
- ctrl_out  out  CTRL_W  control bits, gated to 0 when out_valid=0.
- dest_out  out  DEST_W  destination tag.
- data_out  out  DATA_W*NUM_WORDS  packed data words.
- occupancy  out  2  entries held (0..2).
- flush_cnt  out  CNT_W  saturating count of valid entries discarded by flush.

Behaviour:
- Storage: main entry M (valid bit mv) drives the outputs; skid entry S has valid bit sv.
- Reset (async, rst=1):
  - mv, sv, flush_cnt, and all M/S payload fields go to 0.
  - Therefore out_valid=0, ctrl_out=0, dest_out=0, data_out=0, occupancy=0.
  - in_ready=0 while rst is asserted; in_ready=1 on the first cycle after release.
- Combinational outputs, all registered-derived with no input-to-output path:
  - in_ready = ~sv & ~freeze & ~rst.
  - out_valid = mv.
  - ctrl_out = mv ? M.ctrl : 0.
  - occupancy = mv + sv.
- Transfer definitions:
  - acc = in_valid & in_ready.
  - deq = mv & out_ready & ~freeze.
- Priority each clock edge: flush > freeze > normal.
- flush=1:
  - Next state is mv=0, sv=0.
  - A deq in the same cycle completes normally (downstream keeps it).
  - Input in the same cycle is discarded even if acc=1.
  - flush_cnt += (mv & ~deq) + sv, saturating at 2^CNT_W-1.
  - Payload registers may hold stale values.
- freeze=1 (no flush): no state change; no transfer counted, even if out_ready=1.
- Normal operation, exactly one case applies:
  - mv=0: acc loads M, mv=1.
  - mv=1, sv=0, deq & acc: M <= input.
  - mv=1, sv=0, deq & ~acc: mv=0.
  - mv=1, sv=0, ~deq & acc: S <= input, sv=1.
  - mv=1, sv=1: in_ready=0; on deq, M <= S and sv=0.
  - Otherwise: hold.
- Latency:
  - Input accepted at edge k appears on outputs after edge k (1 cycle) when M is free or being dequeued.
  - With sustained out_ready=1 and no freeze/flush, throughput is 1 entry/cycle.
- Ordering: strict FIFO, 2 deep; no entry is duplicated or lost except by flush.
- Payload is captured only on acc; data_out and dest_out hold their last values when out_valid=0.
- Reset mid-operation discards all entries immediately and does not increment flush_cnt.

Test Plan:
- Reset, then stream A=0x11, B=0x22, C=0x33 with out_ready=1, in_valid=1 -> outputs A, B, C on consecutive cycles, each 1 cycle after acceptance; occupancy=1 throughout; in_ready=1.
- Load A and B with out_ready=0 -> after 2 edges occupancy=2, in_ready=0, data_out=A. Raise out_ready -> A, then B, dequeued on consecutive cycles; in_ready=1 again after the first deq.
- Hold 2 entries, ctrl_in=3'b101 for both, assert flush with out_ready=0 -> next cycle out_valid=0, ctrl_out=0, occupancy=0, flush_cnt=2. Flush with out_ready=1 and 2 entries -> flush_cnt +1 only.
- freeze=1 with 1 entry, out_ready=1, in_valid=1 for 3 cycles -> in_ready=0, outputs and occupancy constant. Release -> normal dequeue resumes.
- CNT_W=2: 5 flushes of 1 entry each -> flush_cnt reads 1, 2, 3, 3, 3.
- Assert rst asynchronously mid-stream with occupancy=2 -> all outputs 0 immediately, before the next clock edge; flush_cnt=0; in_ready=1 one cycle after release.
